// File: rtl/int_defs.sv
// Shared definitions for the interrupt/EPC controller.
// Contents: FSM state encoding, default line count and vector base, cause width helper.
package int_defs;

    typedef enum logic {
        IDLE = 1'b0,
        ISR  = 1'b1
    } state_t;

    localparam int unsigned N_IRQ_DEFAULT    = 4;
    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0004;

    // Width of the cause field for n request lines.
    function automatic int unsigned cause_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports: req (N request bits) -> sel (index of lowest set bit, 0 if none), any (some bit set).
module int_prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] sel,
    output logic         any
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        sel = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) sel = W'(i);
        end
    end

endmodule

// File: rtl/int_epc_ctrl.sv
// Interrupt responder: edge-detects irq lines, takes the lowest pending line when
// enabled, saves EPC/cause and redirects the PC to the handler; eret restores EPC.
// Build option: INT_VECTOR_TABLE_EN gives each line its own 4-byte vector slot;
// otherwise every line enters at VEC_BASE and the handler reads cause.
// Ports:
//   clk, rst (async, active-high)
//   irq[N_IRQ], int_en, MIO_ready, eret, pc_next[32]      - inputs
//   int_code, pc_redirect, pc_target[32]                 - combinational outputs
//   epc[32], cause[CAUSE_W], in_isr, eret_err            - registered outputs
module int_epc_ctrl
    import int_defs::*;
#(
    parameter  int unsigned N_IRQ    = N_IRQ_DEFAULT,
    parameter  logic [31:0] VEC_BASE = VEC_BASE_DEFAULT,
    localparam int unsigned CAUSE_W  = cause_width(N_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq,
    input  logic               int_en,
    input  logic               MIO_ready,
    input  logic               eret,
    input  logic [31:0]        pc_next,
    output logic               int_code,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_isr,
    output logic               eret_err
);

    state_t             state;
    logic [N_IRQ-1:0]   irq_q;
    logic [N_IRQ-1:0]   pending;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   clr_mask;
    logic [CAUSE_W-1:0] sel;
    logic               any;
    logic               take;
    logic               ret;
    logic [31:0]        vector;

    int_prio_enc #(
        .N (N_IRQ),
        .W (CAUSE_W)
    ) u_prio (
        .req (pending),
        .sel (sel),
        .any (any)
    );

    assign rise = irq & ~irq_q;
    assign take = (state == IDLE) & int_en & MIO_ready & any;
    assign ret  = (state == ISR) & eret;

`ifdef INT_VECTOR_TABLE_EN
    assign vector = VEC_BASE + (32'(sel) << 2);
`else
    assign vector = VEC_BASE;
`endif

    assign clr_mask = take ? (N_IRQ'(1) << sel) : '0;
    assign in_isr   = (state == ISR);

    // Redirect to the vector on entry, back to EPC on a handler return.
    always_comb begin
        int_code    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        if (take) begin
            int_code    = 1'b1;
            pc_redirect = 1'b1;
            pc_target   = vector;
        end else if (ret) begin
            pc_redirect = 1'b1;
            pc_target   = epc;
        end
    end

    // State, pending capture and EPC/cause save. A new edge on the line being
    // cleared wins, so the request is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_q    <= '0;
            pending  <= '0;
            epc      <= '0;
            cause    <= '0;
            eret_err <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr_mask) | rise;
            case (state)
                IDLE: begin
                    if (eret) eret_err <= 1'b1;
                    if (take) begin
                        epc   <= pc_next;
                        cause <= sel;
                        state <= ISR;
                    end
                end
                ISR: begin
                    if (eret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_epc_ctrl.sv
module tb_int_epc_ctrl;

    localparam int          N  = 4;
    localparam int          CW = 2;
    localparam logic [31:0] VEC_BASE = 32'h0000_0004;
`ifdef INT_VECTOR_TABLE_EN
    localparam bit TABLE = 1'b1;
`else
    localparam bit TABLE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          int_en, MIO_ready, eret;
    logic [31:0]   pc_next;
    logic          int_code, pc_redirect, in_isr, eret_err;
    logic [31:0]   pc_target, epc;
    logic [CW-1:0] cause;

    int_epc_ctrl #(.N_IRQ(N), .VEC_BASE(VEC_BASE)) dut (
        .clk(clk), .rst(rst), .irq(irq), .int_en(int_en), .MIO_ready(MIO_ready),
        .eret(eret), .pc_next(pc_next), .int_code(int_code), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .epc(epc), .cause(cause), .in_isr(in_isr), .eret_err(eret_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ic;
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        isr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model: architectural view of the responder.
    logic [N-1:0] m_pend, m_prev;
    bit           m_isr, m_err;
    logic [31:0]  m_epc;
    int           m_cause;

    function automatic logic [31:0] vec(input int s);
        return TABLE ? VEC_BASE + 32'(s * 4) : VEC_BASE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_isr = 0; m_err = 0; m_epc = '0; m_cause = 0;
    endtask

    // Drive one cycle, push the expected outputs, then advance the model.
    task automatic step(input logic [N-1:0] i_irq, input logic i_en, input logic i_rdy,
                        input logic i_eret, input logic [31:0] i_pc);
        exp_t e;
        bit   take;
        int   s;
        @(posedge clk); #1;
        irq = i_irq; int_en = i_en; MIO_ready = i_rdy; eret = i_eret; pc_next = i_pc;
        s = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && s < 0) s = i;
        take = !m_isr && i_en && i_rdy && (s >= 0);
        e.epc = m_epc; e.cause = 32'(m_cause); e.isr = m_isr; e.err = m_err;
        e.ic = 0; e.rd = 0; e.tgt = '0;
        if (take) begin
            e.ic = 1; e.rd = 1; e.tgt = vec(s);
        end else if (m_isr && i_eret) begin
            e.rd = 1; e.tgt = m_epc;
        end
        q.push_back(e);
        if (!m_isr && i_eret) m_err = 1;
        if (take) begin
            m_epc = i_pc; m_cause = s; m_pend[s] = 1'b0; m_isr = 1;
        end else if (m_isr && i_eret) begin
            m_isr = 0;
        end
        for (int i = 0; i < N; i++) if (i_irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
        m_prev = i_irq;
    endtask

    // Monitor: compare whatever the DUT shows against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("int_code",    32'(int_code),    32'(e.ic));
            chk("pc_redirect", 32'(pc_redirect), 32'(e.rd));
            chk("pc_target",   pc_target,        e.tgt);
            chk("epc",         epc,              e.epc);
            chk("cause",       32'(cause),       e.cause);
            chk("in_isr",      32'(in_isr),      32'(e.isr));
            chk("eret_err",    32'(eret_err),    32'(e.err));
        end
    end

    initial begin
        rst = 1'b1; irq = '0; int_en = 0; MIO_ready = 0; eret = 0; pc_next = '0;
        model_reset();
        #1;
        chk("reset_epc",    epc,              32'h0);
        chk("reset_in_isr", 32'(in_isr),      32'h0);
        chk("reset_redir",  32'(pc_redirect), 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Entry on irq[2] and return
        step(4'b0000, 1, 1, 0, 32'h40);
        step(4'b0100, 1, 1, 0, 32'h40);
        step(4'b0100, 1, 1, 0, 32'h40);
        step(4'b0000, 1, 1, 0, 32'h44);
        step(4'b0000, 1, 1, 1, 32'h48);
        step(4'b0000, 1, 1, 0, 32'h40);

        // Priority: lines 3 and 1 together; 3 taken right after return
        step(4'b1010, 1, 1, 0, 32'h80);
        step(4'b1010, 1, 1, 0, 32'h84);
        step(4'b0000, 1, 1, 0, 32'h88);
        step(4'b0000, 1, 1, 1, 32'h8C);
        step(4'b0000, 1, 1, 0, 32'h80);
        step(4'b0000, 1, 1, 1, 32'h90);

        // MIO_ready hold-off, then int_en hold-off
        step(4'b0001, 1, 0, 0, 32'h100);
        repeat (3) step(4'b0000, 1, 0, 0, 32'h104);
        step(4'b0000, 1, 1, 0, 32'h108);
        step(4'b0000, 1, 1, 1, 32'h10C);
        step(4'b0001, 0, 1, 0, 32'h200);
        repeat (2) step(4'b0000, 0, 1, 0, 32'h204);
        step(4'b0000, 1, 1, 0, 32'h208);
        step(4'b0000, 1, 1, 1, 32'h20C);

        // Stray return sets the sticky error
        step(4'b0000, 1, 1, 1, 32'h300);
        repeat (2) step(4'b0000, 1, 1, 0, 32'h304);

        // New edge on the line being taken stays pending
        step(4'b0001, 0, 1, 0, 32'h400);
        step(4'b0000, 0, 1, 0, 32'h404);
        step(4'b0001, 1, 1, 0, 32'h408);
        step(4'b0000, 1, 1, 1, 32'h40C);
        step(4'b0000, 1, 1, 0, 32'h410);
        step(4'b0000, 1, 1, 1, 32'h414);

        // eret together with a new edge: return happens, edge taken next
        step(4'b0000, 1, 1, 0, 32'h500);
        step(4'b0010, 1, 1, 0, 32'h504);
        step(4'b0010, 1, 1, 0, 32'h508);
        step(4'b0110, 1, 1, 1, 32'h50C);
        step(4'b0000, 1, 1, 0, 32'h508);
        step(4'b0000, 1, 1, 0, 32'h600);

        // Async reset in the middle of a handler, no clock edge involved
        chk("pre_reset_in_isr", 32'(in_isr), 32'(m_isr));
        @(posedge clk); #1;
        irq = '0; eret = 0; int_en = 1; MIO_ready = 1;
        rst = 1'b1;
        #1;
        chk("arst_int_code",  32'(int_code),    32'h0);
        chk("arst_redirect",  32'(pc_redirect), 32'h0);
        chk("arst_target",    pc_target,        32'h0);
        chk("arst_epc",       epc,              32'h0);
        chk("arst_cause",     32'(cause),       32'h0);
        chk("arst_in_isr",    32'(in_isr),      32'h0);
        chk("arst_eret_err",  32'(eret_err),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(N'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end

        @(posedge clk);
        @(negedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
